// File: rtl/pll_reset_seq.sv
// Reset sequencer for the PLL output clock domain. It synchronises and filters LOCK,
// holds every reset through a settle period, then releases the channels one at a time.
module pll_reset_seq #(
    parameter int NUM_RESETS     = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FILTER    = 16,
    parameter int HOLD_CYCLES    = 64,
    parameter int STAGGER_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lock,
    input  logic                  restart,
    output logic [NUM_RESETS-1:0] reset_out,
    output logic                  ready,
    output logic [7:0]            lock_lost_count,
    output logic                  locked_sync
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_FILTER,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX     = 3'(NUM_RESETS - 1);

    // Lock synchroniser: the only place the raw, asynchronous lock is sampled.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge clock) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_RESETS-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [7:0]            lost_q, lost_d;

    logic                  lock_drop;
    logic [2:0]            idx_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        ready_d   = ready_q;
        lost_d    = lost_q;
        idx_next  = idx_q + 3'd1;
        lock_drop = !lock_s &&
                    (state_q == S_HOLD || state_q == S_RELEASE || state_q == S_RUN);

        // Lock loss beats restart, so a simultaneous restart still counts the drop.
        if (lock_drop) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (restart && state_q != S_WAIT_LOCK) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_FILTER;
                        cnt_d   = '0;
                    end
                end

                S_FILTER: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == FILTER_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = 1'b0;
                        // A single channel needs no stagger phase at all.
                        if (NUM_RESETS == 1) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_next;
                        for (int i = 0; i < NUM_RESETS; i++) begin
                            if (idx_next == 3'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        if (idx_next == LAST_IDX) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_RUN: begin
                end

                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign reset_out       = rst_q;
    assign ready           = ready_q;
    assign lock_lost_count = lost_q;
    assign locked_sync     = lock_s;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed timing scenarios plus random lock/restart
// traffic, all compared each cycle against a time-since-lock reference model.
module tb_pll_reset_seq;

    localparam int N  = 3;
    localparam int S  = 2;
    localparam int LF = 16;
    localparam int H  = 64;
    localparam int ST = 8;

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic         lock    = 1'b0;
    logic         restart = 1'b0;
    logic [N-1:0] reset_out;
    logic         ready;
    logic [7:0]   lock_lost_count;
    logic         locked_sync;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: "active" means a sequence is in progress, m_t counts edges since
    // the sequence started; every output is a threshold on m_t.
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_lost   = 0;
    bit m_hist [S];

    pll_reset_seq #(
        .NUM_RESETS    (N),
        .SYNC_STAGES   (S),
        .LOCK_FILTER   (LF),
        .HOLD_CYCLES   (H),
        .STAGGER_CYCLES(ST),
        .CNT_W         (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .lock           (lock),
        .restart        (restart),
        .reset_out      (reset_out),
        .ready          (ready),
        .lock_lost_count(lock_lost_count),
        .locked_sync    (locked_sync)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = !(m_active && m_t >= LF + H + i * ST);
        end
        return r;
    endfunction

    function automatic logic exp_ready();
        return m_active && m_t >= LF + H + (N - 1) * ST;
    endfunction

    always @(posedge clock) begin
        bit ls;
        cyc <= cyc + 1;
        if (reset) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_t      <= 0;
            m_lost   <= 0;
            for (int i = 0; i < S; i++) m_hist[i] <= 1'b0;
        end else begin
            ls = m_hist[S-1];
            if (!m_active) begin
                if (ls) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                end
            end else if (!ls) begin
                if (m_t >= LF && m_lost < 255) m_lost <= m_lost + 1;
                m_active <= 1'b0;
            end else if (restart) begin
                m_active <= 1'b0;
            end else if (m_t < 1000000) begin
                m_t <= m_t + 1;
            end
            for (int i = S - 1; i > 0; i--) m_hist[i] <= m_hist[i-1];
            m_hist[0] <= lock;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model reset_out", 32'(reset_out), 32'(exp_rst()));
            check("model ready", 32'(ready), 32'(exp_ready()));
            check("model lock_lost_count", 32'(lock_lost_count), 32'(m_lost));
            check("model locked_sync", 32'(locked_sync), 32'(m_hist[S-1]));
        end
    end

    // Returns at the falling edge that follows rising edge number `target`.
    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        lock    = 1'b0;
        restart = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int l;
        int r;
        int e1;
        int hi;
        int lo;

        do_reset();
        check("reset reset_out", 32'(reset_out), 32'h7);
        check("reset ready", 32'(ready), 32'h0);
        check("reset count", 32'(lock_lost_count), 32'h0);
        check("reset locked_sync", 32'(locked_sync), 32'h0);

        // Clean lock from E0: channels fall at E0+82/90/98.
        lock = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 81); check("e0+81 rst", 32'(reset_out), 32'h7);
        wait_until(e0 + 82); check("e0+82 rst", 32'(reset_out), 32'h6);
        wait_until(e0 + 89); check("e0+89 rst", 32'(reset_out), 32'h6);
        wait_until(e0 + 90); check("e0+90 rst", 32'(reset_out), 32'h4);
        wait_until(e0 + 97); check("e0+97 ready", 32'(ready), 32'h0);
        wait_until(e0 + 98);
        check("e0+98 rst", 32'(reset_out), 32'h0);
        check("e0+98 ready", 32'(ready), 32'h1);
        check("e0+98 count", 32'(lock_lost_count), 32'h0);

        // One-cycle lock drop in RUN.
        wait_until(e0 + 110);
        lock = 1'b0;
        l = cyc + 1;
        wait_until(l);     lock = 1'b1;
        wait_until(l + 1); check("drop l+1 rst", 32'(reset_out), 32'h0);
        wait_until(l + 2);
        check("drop l+2 rst", 32'(reset_out), 32'h7);
        check("drop l+2 ready", 32'(ready), 32'h0);
        check("drop l+2 count", 32'(lock_lost_count), 32'h1);
        e0 = l + 1;
        wait_until(e0 + 81); check("rerun +81 rst", 32'(reset_out), 32'h7);
        wait_until(e0 + 82); check("rerun +82 rst", 32'(reset_out), 32'h6);
        wait_until(e0 + 98); check("rerun +98 ready", 32'(ready), 32'h1);

        // Restart coinciding with lock_s falling: counted once.
        wait_until(cyc + 5);
        lock = 1'b0;
        l = cyc + 1;
        wait_until(l);     lock = 1'b1;
        wait_until(l + 1); restart = 1'b1;
        wait_until(l + 2); restart = 1'b0;
        check("both rst", 32'(reset_out), 32'h7);
        check("both ready", 32'(ready), 32'h0);
        check("both count", 32'(lock_lost_count), 32'h2);

        // Restart in RELEASE after channel 0 has fallen.
        e0 = l + 1;
        wait_until(e0 + 85); check("release rst", 32'(reset_out), 32'h6);
        restart = 1'b1;
        r = e0 + 86;
        wait_until(r); restart = 1'b0;
        check("restart rst", 32'(reset_out), 32'h7);
        check("restart count", 32'(lock_lost_count), 32'h2);
        wait_until(r + 80); check("restart +80 rst", 32'(reset_out), 32'h7);
        wait_until(r + 81); check("restart +81 rst", 32'(reset_out), 32'h6);

        // Lock glitch during the filter window.
        do_reset();
        lock = 1'b1;
        l = cyc + 1;
        wait_until(l + 9);  lock = 1'b0;
        wait_until(l + 12); lock = 1'b1;
        e1 = l + 13;
        wait_until(e1 + 81); check("glitch +81 rst", 32'(reset_out), 32'h7);
        wait_until(e1 + 82); check("glitch +82 rst", 32'(reset_out), 32'h6);
        check("glitch count", 32'(lock_lost_count), 32'h0);

        // Random lock / restart / reset traffic, checked by the model every cycle.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            hi = $urandom_range(1, 140);
            lo = $urandom_range(1, 5);
            for (int c = 0; c < hi + lo; c++) begin
                lock    = (c < hi);
                restart = ($urandom_range(0, 79) == 0);
                reset   = ($urandom_range(0, 599) == 0);
                @(negedge clock);
            end
        end
        reset   = 1'b0;
        restart = 1'b0;

        // 300 losses saturate the counter.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            lock = 1'b1;
            repeat (25) @(negedge clock);
            lock = 1'b0;
            repeat (2) @(negedge clock);
        end
        check("saturated count", 32'(lock_lost_count), 32'd255);

        // Reset mid-RELEASE.
        lock = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 92); check("pre-reset rst", 32'(reset_out), 32'h4);
        reset = 1'b1;
        wait_until(e0 + 93); reset = 1'b0;
        check("mid reset rst", 32'(reset_out), 32'h7);
        check("mid reset ready", 32'(ready), 32'h0);
        check("mid reset count", 32'(lock_lost_count), 32'h0);
        check("mid reset locked_sync", 32'(locked_sync), 32'h0);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
